// File: rtl/mul_share_arbiter.sv
// -----------------------------------------------------------------------------
// mul_share_arbiter
//   Lets NUM_REQ client blocks take turns on one sequential signed multiplier.
//   Round-robin arbitration, valid/ready handshakes on the request and
//   response sides. The arbiter drives the multiplier's load/reset line, holds
//   its operands stable for the whole run and captures the product.
//
// Ports
//   clk, rst    rising-edge clock, asynchronous active-high reset
//   req_valid   per-requester request valid
//   req_ready   one-hot accept pulse to the granted requester (combinational)
//   req_a/req_x packed signed operands, slice i belongs to requester i
//   rsp_valid   result valid (held until rsp_ready)
//   rsp_ready   result consumer ready
//   rsp_id      index of the requester owning the result
//   rsp_p       signed product
//   mul_rst     multiplier reset/load (high loads operands)
//   mul_a/mul_x operands to the multiplier
//   mul_p       multiplier product
//   busy        high whenever a transaction is in flight
// -----------------------------------------------------------------------------
module mul_share_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int WIDTH      = 32,
    parameter int MUL_CYCLES = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_REQ-1:0]         req_valid,
    output logic [NUM_REQ-1:0]         req_ready,
    input  logic [NUM_REQ*WIDTH-1:0]   req_a,
    input  logic [NUM_REQ*WIDTH-1:0]   req_x,
    output logic                       rsp_valid,
    input  logic                       rsp_ready,
    output logic [$clog2(NUM_REQ)-1:0] rsp_id,
    output logic [2*WIDTH-1:0]         rsp_p,
    output logic                       mul_rst,
    output logic [WIDTH-1:0]           mul_a,
    output logic [WIDTH-1:0]           mul_x,
    input  logic [2*WIDTH-1:0]         mul_p,
    output logic                       busy
);

    localparam int IDW = $clog2(NUM_REQ);
    localparam int CW  = (MUL_CYCLES > 1) ? $clog2(MUL_CYCLES) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_RUN,
        S_DONE
    } state_t;

    state_t         state, state_nxt;
    logic [IDW-1:0] ptr;      // last granted requester
    logic [IDW-1:0] gid;      // requester owning the current transaction
    logic [IDW-1:0] grant;
    logic [IDW-1:0] cand;
    logic           found;
    logic [CW-1:0]  cnt;

    // Round-robin search: first valid index starting just after the last grant.
    // NOTE: every signal written in a combinational block gets a default first,
    // so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        found = 1'b0;
        grant = '0;
        cand  = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = IDW'((int'(ptr) + k) % NUM_REQ);
            if (!found && req_valid[cand]) begin
                found = 1'b1;
                grant = cand;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        req_ready = '0;
        unique case (state)
            S_IDLE: begin
                // Gated by rst so the accept pulse is silent while reset is held.
                if (found && !rst) begin
                    req_ready[grant] = 1'b1;
                    state_nxt        = S_LOAD;
                end
            end
            S_LOAD: state_nxt = S_RUN;
            S_RUN:  if (cnt == '0) state_nxt = S_DONE;
            S_DONE: if (rsp_ready) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // The multiplier iterates only in RUN; everywhere else it is held loaded.
    assign mul_rst   = (state != S_RUN);
    assign rsp_valid = (state == S_DONE);
    assign busy      = (state != S_IDLE);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of the others, independent of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= S_IDLE;
            ptr    <= IDW'(NUM_REQ - 1);
            gid    <= '0;
            cnt    <= '0;
            mul_a  <= '0;
            mul_x  <= '0;
            rsp_p  <= '0;
            rsp_id <= '0;
        end else begin
            state <= state_nxt;
            unique case (state)
                S_IDLE: begin
                    if (found) begin
                        mul_a <= req_a[grant*WIDTH +: WIDTH];
                        mul_x <= req_x[grant*WIDTH +: WIDTH];
                        gid   <= grant;
                        ptr   <= grant;
                    end
                end
                S_LOAD: cnt <= CW'(MUL_CYCLES - 1);
                S_RUN: begin
                    if (cnt == '0) begin
                        rsp_p  <= mul_p;
                        rsp_id <= gid;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
